// File: rtl/fp_accum_seq.sv
// fp_accum_seq: sequential accumulator for IEEE-754 single-precision vectors.
// The block does no floating-point arithmetic of its own. Each partial sum is
// produced by an external combinational adder (add_a/add_b -> add_sum) and is
// stored bit-exact.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_data/in_valid/    element stream; in_last marks the final element
//   in_last/in_ready     of a vector
//   add_a/add_b/add_sum  interface to the external combinational FP adder
//   out_data/out_count/  result (sum and saturating element count) and its
//   out_valid/out_ready  handshake
module fp_accum_seq #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        in_data,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic [31:0]        add_a,
  output logic [31:0]        add_b,
  input  logic [31:0]        add_sum,
  output logic [31:0]        out_data,
  output logic [COUNT_W-1:0] out_count,
  output logic               out_valid,
  input  logic               out_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    ADD   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  state_t             state;
  state_t             state_nxt;
  logic [31:0]        acc;
  logic [31:0]        b_reg;
  logic [COUNT_W-1:0] count;
  logic               last_reg;

  // Element count sticks at all-ones rather than wrapping back to zero.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + COUNT_W'(1);
  endfunction

  // Adder operands come straight from registers, so they stay still while
  // in_data toggles; the adder output is only consumed in ADD.
  assign add_a     = acc;
  assign add_b     = b_reg;
  assign out_data  = acc;
  assign out_count = count;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = in_last ? DONE : ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ADD;
      end
      ADD: begin
        state_nxt = last_reg ? DONE : ACCUM;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      b_reg    <= '0;
      count    <= '0;
      last_reg <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        // First element of a vector seeds the accumulator without an add;
        // this also overwrites whatever the previous vector left behind.
        IDLE: begin
          if (in_valid) begin
            acc   <= in_data;
            count <= COUNT_W'(1);
          end
        end
        ACCUM: begin
          if (in_valid) begin
            b_reg    <= in_data;
            last_reg <= in_last;
          end
        end
        ADD: begin
          acc   <= add_sum;
          count <= sat_inc(count);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_accum_seq.sv
// Testbench for fp_accum_seq: directed vectors plus randomized integer-valued
// vectors, checked against a real-arithmetic reference sum. Two instances run
// in lockstep: the default COUNT_W and COUNT_W=2 for count saturation.
module tb_fp_accum_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid;
  logic [31:0] add_a, add_b, add_sum, out_data;
  logic [7:0]  out_count;

  logic        in_ready2, out_valid2;
  logic [31:0] add_a2, add_b2, add_sum2, out_data2;
  logic [1:0]  out_count2;

  int checks = 0;
  int errors = 0;
  logic [31:0] vq[$];

  always #5 clk = ~clk;

  // Single <-> double conversion for normal numbers and +0, which is all the
  // stimulus uses (integer values of small magnitude, so sums are exact).
  function automatic real f2r(input logic [31:0] f);
    logic [10:0] e;
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    e = {3'b000, f[30:23]} + 11'd896;
    d = {f[31], e, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] model_sum();
    real s;
    s = 0.0;
    foreach (vq[i]) s = s + f2r(vq[i]);
    return r2f(s);
  endfunction

  // External combinational FP adders.
  assign add_sum  = r2f(f2r(add_a)  + f2r(add_b));
  assign add_sum2 = r2f(f2r(add_a2) + f2r(add_b2));

  fp_accum_seq #(.COUNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .add_a(add_a), .add_b(add_b),
    .add_sum(add_sum), .out_data(out_data), .out_count(out_count),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  fp_accum_seq #(.COUNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready2), .add_a(add_a2), .add_b(add_b2),
    .add_sum(add_sum2), .out_data(out_data2), .out_count(out_count2),
    .out_valid(out_valid2), .out_ready(out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_data"},  out_data,       32'd0);
    chk({tag, "_out_count"}, 32'(out_count), 32'd0);
    chk({tag, "_add_a"},     add_a,          32'd0);
    chk({tag, "_add_b"},     add_b,          32'd0);
  endtask

  // Offer one element (after 'gap' idle cycles) until accepted. With junk set,
  // random in_valid/in_last/in_data are left on the bus across the next edge,
  // where the block is expected not to be ready.
  task automatic push(input logic [31:0] d, input logic l, input bit junk, input int gap);
    int k;
    k = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("accept_wait", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = junk ? 1'($urandom) : 1'b0;
    in_last  = 1'($urandom);
    in_data  = $urandom;
  endtask

  task automatic take_result(input logic [31:0] exp_d, input int cnt, input int stall);
    int cnt2;
    cnt2 = (cnt > 3) ? 3 : cnt;
    @(negedge clk);
    chk("res_out_valid",  32'(out_valid),  32'd1);
    chk("res_out_data",   out_data,        exp_d);
    chk("res_out_count",  32'(out_count),  32'(cnt));
    chk("res_out_data2",  out_data2,       exp_d);
    chk("res_out_count2", 32'(out_count2), 32'(cnt2));
    chk("res_in_ready",   32'(in_ready),   32'd0);
    repeat (stall) begin
      in_valid = 1'b1;
      in_last  = 1'($urandom);
      in_data  = $urandom;
      @(negedge clk);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_out_data",  out_data,       exp_d);
      chk("stall_out_count", 32'(out_count), 32'(cnt));
      chk("stall_in_ready",  32'(in_ready),  32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("post_out_valid",  32'(out_valid),  32'd0);
    chk("post_in_ready",   32'(in_ready),   32'd1);
    chk("post_out_valid2", 32'(out_valid2), 32'd0);
    chk("post_in_ready2",  32'(in_ready2),  32'd1);
  endtask

  // Push the elements of vq, checking handshake timing after each acceptance,
  // then collect and check the result.
  task automatic run_vector(input logic [31:0] exp_d, input int stall, input bit gaps);
    int n;
    logic l;
    n = vq.size();
    for (int i = 0; i < n; i++) begin
      l = (i == n - 1);
      push(vq[i], l, (i > 0) || l, gaps ? int'($urandom_range(0, 2)) : 0);
      @(negedge clk);
      chk("acc_in_ready",  32'(in_ready),  32'(i == 0 && !l));
      chk("acc_out_valid", 32'(out_valid), 32'(i == 0 && l));
      if (i > 0) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
      end
    end
    take_result(exp_d, n, stall);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int x;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("rst_hold");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs("rst_after");

    // Single element with last set in IDLE.
    vq = {};
    vq.push_back(32'h3F800000);
    run_vector(32'h3F800000, 0, 1'b0);

    // 1.0 + 2.0 + 3.0 back to back.
    vq = {};
    vq.push_back(32'h3F800000);
    vq.push_back(32'h40000000);
    vq.push_back(32'h40400000);
    run_vector(32'h40C00000, 0, 1'b0);

    // Result held under 5 cycles of backpressure.
    vq = {};
    vq.push_back(32'h40000000);
    vq.push_back(32'h40400000);
    run_vector(32'h40A00000, 5, 1'b0);

    // Reset in the middle of a vector.
    push(32'h3F800000, 1'b0, 1'b0, 0);
    push(32'h40000000, 1'b0, 1'b1, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs("rst_mid");
    vq = {};
    vq.push_back(32'h40000000);
    run_vector(32'h40000000, 0, 1'b0);

    // Five 1.0 elements: narrow counter saturates at 3.
    vq = {};
    repeat (5) vq.push_back(32'h3F800000);
    run_vector(32'h40A00000, 0, 1'b0);

    // Exact cancellation.
    vq = {};
    vq.push_back(32'h40000000);
    vq.push_back(32'hC0000000);
    run_vector(32'h00000000, 1, 1'b0);

    // Randomized integer-valued vectors with idle gaps and backpressure.
    for (int r = 0; r < 10; r++) begin
      n = int'($urandom_range(1, 7));
      vq = {};
      for (int j = 0; j < n; j++) begin
        x = int'($urandom_range(0, 100)) - 50;
        vq.push_back(r2f(real'(x)));
      end
      run_vector(model_sum(), int'($urandom_range(0, 3)), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
